sync_position_counter: RTL and testbench



---
 rtl/sync_position_counter_if.sv | 57 +++++
 rtl/sync_position_counter.sv | 154 +++++++++++++++
 tb/tb_sync_position_counter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_position_counter_if.sv
// Sync-stream bundle between a raw camera/VGA source and the position counter.
// Latency: none, wires only.
// Backpressure: none; the pixel stream is free-running and paced by the pixel clock.
interface sync_position_counter_if;

    // Raw sync stream from the sensor/timing generator
    logic        vga_hs;
    logic        vga_vs;
    logic [23:0] pixel_in;

    // Pixel tagged with its coordinates, plus timing measurements
    logic [12:0] row;
    logic [12:0] col;
    logic [23:0] pixel_out;
    logic        hs_out;
    logic        vs_out;
    logic        line_tick;
    logic        frame_tick;
    logic [12:0] line_len;
    logic [12:0] frame_lines;
    logic        locked;

    // Source side: drives the raw stream, observes the tagged stream
    modport master (
        output vga_hs,
        output vga_vs,
        output pixel_in,
        input  row,
        input  col,
        input  pixel_out,
        input  hs_out,
        input  vs_out,
        input  line_tick,
        input  frame_tick,
        input  line_len,
        input  frame_lines,
        input  locked
    );

    // Counter side: consumes the raw stream, produces the tagged stream
    modport slave (
        input  vga_hs,
        input  vga_vs,
        input  pixel_in,
        output row,
        output col,
        output pixel_out,
        output hs_out,
        output vs_out,
        output line_tick,
        output frame_tick,
        output line_len,
        output frame_lines,
        output locked
    );

endinterface

// File: rtl/sync_position_counter.sv
// Tags each raw pixel with its row/col, measures line/frame size and flags stable timing.
// Latency: 2 clk from input sample to row/col/pixel_out/hs_out/vs_out.
// Backpressure: none; one pixel accepted and produced every clock.
module sync_position_counter #(
    parameter bit          SYNC_ACTIVE_LOW = 1'b1,
    parameter logic [12:0] CNT_MAX         = 13'h1FFF
) (
    input logic                    clk,
    input logic                    rst,
    sync_position_counter_if.slave bus
);

    // First pipeline stage: normalised sync levels plus the raw sample
    typedef struct packed {
        logic        hs_a;
        logic        vs_a;
        logic        hs_raw;
        logic        vs_raw;
        logic [23:0] pix;
    } stage1_t;

    // Output stage: everything that leaves the block, updated together
    typedef struct packed {
        logic [12:0] row;
        logic [12:0] col;
        logic [23:0] pix;
        logic        hs_raw;
        logic        vs_raw;
        logic        line_tick;
        logic        frame_tick;
        logic [12:0] line_len;
        logic [12:0] frame_lines;
        logic        locked;
    } out_t;

    stage1_t     s1_d;
    stage1_t     s1_q;
    logic        prev_hs_d;
    logic        prev_hs_q;
    logic        prev_vs_d;
    logic        prev_vs_q;
    out_t        out_d;
    out_t        out_q;
    logic        hs_start;
    logic        vs_start;
    logic [12:0] frame_lines_new;

    // Counters stick at CNT_MAX instead of wrapping, so a missing sync edge
    // shows up as a pinned coordinate rather than a plausible-looking one.
    function automatic logic [12:0] sat_inc(input logic [12:0] v);
        if (v >= CNT_MAX) begin
            return CNT_MAX;
        end
        return v + 13'd1;
    endfunction

    // Normalise sync polarity so everything downstream treats 1 as asserted
    always_comb begin
        s1_d        = '0;
        s1_d.hs_a   = bus.vga_hs ^ SYNC_ACTIVE_LOW;
        s1_d.vs_a   = bus.vga_vs ^ SYNC_ACTIVE_LOW;
        s1_d.hs_raw = bus.vga_hs;
        s1_d.vs_raw = bus.vga_vs;
        s1_d.pix    = bus.pixel_in;
    end

    // Stage-1 register; clears to inactive sync so an already-asserted level
    // after reset is seen as a fresh start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
        end else begin
            s1_q <= s1_d;
        end
    end

    // Previous stage-1 sync levels for edge detection
    always_comb begin
        prev_hs_d = s1_q.hs_a;
        prev_vs_d = s1_q.vs_a;
    end

    assign hs_start = s1_q.hs_a & ~prev_hs_q;
    assign vs_start = s1_q.vs_a & ~prev_vs_q;

    // Height of the frame that just ended: the last row index plus one
    assign frame_lines_new = sat_inc(out_q.row);

    // Coordinate, tick and measurement update for the sample now in stage 1
    always_comb begin
        out_d            = out_q;
        out_d.pix        = s1_q.pix;
        out_d.hs_raw     = s1_q.hs_raw;
        out_d.vs_raw     = s1_q.vs_raw;
        out_d.line_tick  = hs_start;
        out_d.frame_tick = vs_start;

        // Column restarts on a line start, otherwise advances and saturates
        if (hs_start) begin
            out_d.col      = '0;
            out_d.line_len = sat_inc(out_q.col);
        end else begin
            out_d.col      = sat_inc(out_q.col);
        end

        // Frame start wins over line start so a coincident pair lands on row 0
        if (vs_start) begin
            out_d.row = '0;
        end else if (hs_start) begin
            out_d.row = sat_inc(out_q.row);
        end

        // Lock needs two consecutive identical, nonzero frame heights
        if (vs_start) begin
            out_d.frame_lines = frame_lines_new;
            out_d.locked      = (frame_lines_new == out_q.frame_lines) &&
                                (frame_lines_new != '0);
        end
    end

    // Stage-2 registers: edge-detect history and all outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_hs_q <= 1'b0;
            prev_vs_q <= 1'b0;
            out_q     <= '0;
        end else begin
            prev_hs_q <= prev_hs_d;
            prev_vs_q <= prev_vs_d;
            out_q     <= out_d;
        end
    end

    assign bus.row         = out_q.row;
    assign bus.col         = out_q.col;
    assign bus.pixel_out   = out_q.pix;
    assign bus.hs_out      = out_q.hs_raw;
    assign bus.vs_out      = out_q.vs_raw;
    assign bus.line_tick   = out_q.line_tick;
    assign bus.frame_tick  = out_q.frame_tick;
    assign bus.line_len    = out_q.line_len;
    assign bus.frame_lines = out_q.frame_lines;
    assign bus.locked      = out_q.locked;

    // Invariants the overlay stage relies on: ticks always coincide with a
    // zero coordinate, and lock never claims a zero-height frame
    a_line_tick_col0 : assert property (@(posedge clk) disable iff (rst)
        out_q.line_tick |-> (out_q.col == '0));
    a_frame_tick_row0 : assert property (@(posedge clk) disable iff (rst)
        out_q.frame_tick |-> (out_q.row == '0));
    a_locked_nonzero : assert property (@(posedge clk) disable iff (rst)
        out_q.locked |-> (out_q.frame_lines != '0));

endmodule

// File: tb/tb_sync_position_counter.sv
module tb_sync_position_counter;

    localparam bit AL    = 1'b1;
    localparam int MAXC  = 8191;
    localparam int FRAME = 8400;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sync_position_counter_if bus ();

    sync_position_counter #(
        .SYNC_ACTIVE_LOW (AL),
        .CNT_MAX         (13'h1FFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: coordinates as distances from the last line/frame start
    typedef struct {
        int          n;
        int          col_org;
        int          hs_cnt;
        bit          p_hs_a;
        bit          p_vs_a;
        bit          p_hs_raw;
        bit          p_vs_raw;
        logic [23:0] p_pix;
        bit          q_hs_a;
        bit          q_vs_a;
        int          row;
        int          col;
        int          ll;
        int          fl;
        bit          lt;
        bit          ft;
        bit          lock;
        bit          hs_o;
        bit          vs_o;
        logic [23:0] pix_o;
    } mstate_t;

    mstate_t st;

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input bit r_in, input bit hs,
                                           input bit vs, input logic [23:0] pix);
        mstate_t r;
        bit      hs_st;
        bit      vs_st;
        r   = s;
        r.n = s.n + 1;
        if (r_in) begin
            r.col_org = r.n;   r.hs_cnt = 0;
            r.p_hs_a = 0;      r.p_vs_a = 0;   r.p_hs_raw = 0; r.p_vs_raw = 0; r.p_pix = '0;
            r.q_hs_a = 0;      r.q_vs_a = 0;
            r.row = 0; r.col = 0; r.ll = 0; r.fl = 0;
            r.lt = 0;  r.ft = 0;  r.lock = 0; r.hs_o = 0; r.vs_o = 0; r.pix_o = '0;
            return r;
        end
        hs_st = s.p_hs_a && !s.q_hs_a;
        vs_st = s.p_vs_a && !s.q_vs_a;
        if (hs_st) begin
            r.ll      = sat(r.n - s.col_org);
            r.col_org = r.n;
        end
        r.col = sat(r.n - r.col_org);
        if (vs_st) begin
            r.fl     = sat(s.row + 1);
            r.lock   = (r.fl == s.fl) && (r.fl != 0);
            r.hs_cnt = 0;
        end else if (hs_st) begin
            r.hs_cnt = s.hs_cnt + 1;
        end
        r.row      = sat(r.hs_cnt);
        r.lt       = hs_st;
        r.ft       = vs_st;
        r.pix_o    = s.p_pix;
        r.hs_o     = s.p_hs_raw;
        r.vs_o     = s.p_vs_raw;
        r.q_hs_a   = s.p_hs_a;
        r.q_vs_a   = s.p_vs_a;
        r.p_hs_a   = hs ^ AL;
        r.p_vs_a   = vs ^ AL;
        r.p_hs_raw = hs;
        r.p_vs_raw = vs;
        r.p_pix    = pix;
        return r;
    endfunction

    function automatic logic [80:0] dut_vec();
        return {bus.row, bus.col, bus.pixel_out, bus.hs_out, bus.vs_out, bus.line_tick,
                bus.frame_tick, bus.line_len, bus.frame_lines, bus.locked};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_model();
        logic [80:0] exp;
        logic [80:0] act;
        exp = {13'(st.row), 13'(st.col), st.pix_o, st.hs_o, st.vs_o, st.lt, st.ft,
               13'(st.ll), 13'(st.fl), st.lock};
        act = dut_vec();
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL model n=%0d: got row=%0d col=%0d pix=%h hs=%b vs=%b lt=%b ft=%b len=%0d lines=%0d lock=%b; want row=%0d col=%0d pix=%h hs=%b vs=%b lt=%b ft=%b len=%0d lines=%0d lock=%b",
                     st.n, bus.row, bus.col, bus.pixel_out, bus.hs_out, bus.vs_out, bus.line_tick,
                     bus.frame_tick, bus.line_len, bus.frame_lines, bus.locked,
                     st.row, st.col, st.pix_o, st.hs_o, st.vs_o, st.lt, st.ft, st.ll, st.fl, st.lock);
        end
    endtask

    // One clock: drive at the falling edge, sample after the next falling edge
    task automatic step(input bit r_in, input bit hs, input bit vs, input logic [23:0] pix,
                        input bit mchk);
        rst          = r_in;
        bus.vga_hs   = hs;
        bus.vga_vs   = vs;
        bus.pixel_in = pix;
        @(posedge clk);
        st = model_next(st, r_in, hs, vs, pix);
        @(negedge clk);
        if (mchk) check_model();
    endtask

    // Hand-derived vectors: reset, coincident HS/VS start, reset with HS held active
    typedef struct packed {
        logic        rst;
        logic        hs;
        logic        vs;
        logic [23:0] pix;
        logic [12:0] row;
        logic [12:0] col;
        logic [23:0] pix_o;
        logic        hs_o;
        logic        vs_o;
        logic        lt;
        logic        ft;
        logic [12:0] ll;
        logic [12:0] fl;
        logic        lock;
    } vec_t;

    function automatic vec_t mk(input int r, input int hs, input int vs, input int pix,
                                input int row, input int col, input int pix_o, input int hs_o,
                                input int vs_o, input int lt, input int ft, input int ll,
                                input int fl, input int lock);
        vec_t v;
        v.rst  = r[0];     v.hs   = hs[0];   v.vs   = vs[0];   v.pix   = 24'(pix);
        v.row  = 13'(row); v.col  = 13'(col); v.pix_o = 24'(pix_o);
        v.hs_o = hs_o[0];  v.vs_o = vs_o[0]; v.lt   = lt[0];    v.ft    = ft[0];
        v.ll   = 13'(ll);  v.fl   = 13'(fl); v.lock = lock[0];
        return v;
    endfunction

    vec_t tbl[13];

    initial begin
        logic [80:0] exp_v;
        logic [23:0] pix;
        mstate_t     pred;
        bit          hs;
        bit          vs;
        bit          r_in;
        bit          done_rst;
        int          rst_t;
        int          k;
        int          tf;
        int          line;

        tbl[0]  = mk(1, 1, 1, 'hA00000, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 'hA00001, 0, 1, 0,        0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 'hA00002, 0, 2, 'hA00001, 1, 1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 'hA00003, 0, 0, 'hA00002, 0, 0, 1, 1, 3, 1, 0);
        tbl[4]  = mk(0, 1, 1, 'hA00004, 0, 1, 'hA00003, 0, 0, 0, 0, 3, 1, 0);
        tbl[5]  = mk(0, 1, 1, 'hA00005, 0, 2, 'hA00004, 1, 1, 0, 0, 3, 1, 0);
        tbl[6]  = mk(0, 0, 1, 'hA00006, 0, 3, 'hA00005, 1, 1, 0, 0, 3, 1, 0);
        tbl[7]  = mk(0, 1, 1, 'hA00007, 1, 0, 'hA00006, 0, 1, 1, 0, 4, 1, 0);
        tbl[8]  = mk(0, 1, 1, 'hA00008, 1, 1, 'hA00007, 1, 1, 0, 0, 4, 1, 0);
        tbl[9]  = mk(1, 0, 1, 'hA00009, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 1, 'hA0000A, 0, 1, 0,        0, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(0, 1, 1, 'hA0000B, 1, 0, 'hA0000A, 0, 1, 1, 0, 2, 0, 0);
        tbl[12] = mk(0, 1, 1, 'hA0000C, 1, 1, 'hA0000B, 1, 1, 0, 0, 2, 0, 0);

        st           = model_next(st, 1'b1, 1'b1, 1'b1, '0);
        st.n         = 0;
        st.col_org   = 0;
        rst          = 1'b1;
        bus.vga_hs   = 1'b1;
        bus.vga_vs   = 1'b1;
        bus.pixel_in = '0;
        @(negedge clk);

        // Table-driven corner cases
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].rst, tbl[i].hs, tbl[i].vs, tbl[i].pix, 1'b1);
            exp_v = {tbl[i].row, tbl[i].col, tbl[i].pix_o, tbl[i].hs_o, tbl[i].vs_o,
                     tbl[i].lt, tbl[i].ft, tbl[i].ll, tbl[i].fl, tbl[i].lock};
            n_vec++;
            if (dut_vec() !== exp_v) begin
                n_err++;
                $display("FAIL table[%0d]: got %h, want %h", i, dut_vec(), exp_v);
            end
        end

        // 800-clk lines with pixel carrying its own predicted coordinates,
        // and a one-clock reset in the middle of the third line
        step(1'b1, 1'b1, 1'b1, '0, 1'b1);
        done_rst = 1'b0;
        rst_t    = -100;
        for (int t = 0; t < 2400; t++) begin
            hs   = !((t % 800) < 96);
            r_in = 1'b0;
            if (!done_rst && t >= 1600 && st.col == 400) begin
                r_in     = 1'b1;
                done_rst = 1'b1;
                rst_t    = t;
            end
            pred = model_next(model_next(st, r_in, hs, 1'b1, '0), 1'b0, 1'b1, 1'b1, '0);
            pix  = {11'(pred.row), 13'(pred.col)};
            step(r_in, hs, 1'b1, pix, 1'b1);
            if (r_in) begin
                n_vec++;
                if (dut_vec() !== '0) begin
                    n_err++;
                    $display("FAIL reset_all_zero: got %h, want 0", dut_vec());
                end
            end else if (t != 0 && t != rst_t + 1) begin
                chk("pix_col_align", int'(bus.pixel_out[12:0]), st.col);
                chk("pix_row_align", int'(bus.pixel_out[23:13]), st.row % 2048);
            end
            if (t == 801) chk("line_len_800", int'(bus.line_len), 800);
            if (t == rst_t + 10) chk("col_after_reset", int'(bus.col), 10);
        end

        // 525-line frames of 16-clk lines, then same frame period with 20-clk lines
        for (int t = 0; t <= 5 * FRAME + 50; t++) begin
            k    = t / FRAME;
            tf   = t % FRAME;
            line = (k < 4) ? 16 : 20;
            hs   = !((tf % line) < 4);
            vs   = !(tf < 32);
            step(1'b0, hs, vs, 24'($urandom), 1'b1);
            if (tf == 1 && k >= 1) begin
                chk("frame_tick", int'(bus.frame_tick), 1);
                chk("frame_row0", int'(bus.row), 0);
                chk("frame_col0", int'(bus.col), 0);
                chk("frame_lines", int'(bus.frame_lines), (k == 5) ? 420 : 525);
                chk("locked", int'(bus.locked), (k >= 2 && k <= 4) ? 1 : 0);
            end
        end

        // HS held inactive long enough to saturate the column
        for (int i = 0; i < 9000; i++) step(1'b0, 1'b1, 1'b1, 24'($urandom), 1'b1);
        chk("col_saturated", int'(bus.col), MAXC);
        chk("no_line_tick", int'(bus.line_tick), 0);
        step(1'b0, 1'b0, 1'b1, '0, 1'b1);
        step(1'b0, 1'b1, 1'b1, '0, 1'b1);
        chk("sat_line_len", int'(bus.line_len), MAXC);
        chk("sat_restart_col", int'(bus.col), 0);

        // Random sync activity with occasional resets
        step(1'b1, 1'b1, 1'b1, '0, 1'b1);
        hs = 1'b1;
        vs = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)   hs = ~hs;
            if ($urandom_range(0, 63) == 0)  vs = ~vs;
            r_in = ($urandom_range(0, 299) == 0);
            step(r_in, hs, vs, 24'($urandom), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
